packet_forwarder: RTL and testbench

//  Read side of the packet buffer. When the CPU accepts a packet, this block drains it out of packet_ram, one 32-bit word per cycle.
//  It issues sequential reads on the RAM's addra/rd_en port and takes the upper word of doa.
//  It emits an AXI-Stream-style beat stream (tdata/tvalid/tready/tlast) and pulses fwd_done; packetmem ORs fwd_done into len_rst.

---
 rtl/packet_forwarder.sv | 199 +++++++++++++++++++
 tb/tb_packet_forwarder.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_forwarder.sv
// ---------------------------------------------------------------------------
// packet_forwarder
//
// Read side of the packet buffer. When the CPU accepts a packet, this block
// drains words 0..last_addr out of packet_ram, one word per cycle. The words
// leave as an AXI-Stream-style beat stream. A one-cycle fwd_done pulse follows
// the final handshake, and packetmem uses it to clear the stored length.
//
// Ports
//   clk          sole clock, all logic on posedge
//   rst          synchronous, active-high reset
//   start        begin forwarding (only looked at while idle)
//   len          last written word address; bits above ADDR_WIDTH ignored
//   busy         high from the cycle after start until the fwd_done cycle
//   ram_addr     read address to packet_ram addra
//   ram_rd_en    read enable to packet_ram
//   ram_rd_data  upper word of packet_ram doa, valid one cycle after rd_en
//   tdata        output beat data
//   tvalid       output beat valid
//   tready       downstream accept
//   tlast        marks the final beat of the packet
//   fwd_done     one-cycle pulse in the cycle after the tlast handshake
//   last_bytes   (PACKET_FORWARDER_TKEEP_EN only) valid bytes in final word
//   tkeep        (PACKET_FORWARDER_TKEEP_EN only) byte enables, byte 0 = MSB
//
// Build option
//   PACKET_FORWARDER_TKEEP_EN : adds last_bytes/tkeep for partial last words
// ---------------------------------------------------------------------------
module packet_forwarder #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [31:0]           len,
   output logic                  busy,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic                  ram_rd_en,
   input  logic [DATA_WIDTH-1:0] ram_rd_data,
   output logic [DATA_WIDTH-1:0] tdata,
   output logic                  tvalid,
   input  logic                  tready,
   output logic                  tlast,
`ifdef PACKET_FORWARDER_TKEEP_EN
   input  logic [2:0]            last_bytes,
   output logic [3:0]            tkeep,
`endif
   output logic                  fwd_done
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN
   } state_t;

   state_t                  state;
   state_t                  next_state;
   logic [ADDR_WIDTH-1:0]   last_addr;
   logic                    inflight;
   logic                    inflight_last;
   logic [DATA_WIDTH-1:0]   fifo_data [2];
   logic                    fifo_last [2];
   logic                    wr_ptr;
   logic                    rd_ptr;
   logic [1:0]              fifo_count;
   logic                    pop;
   logic                    push;
   logic                    issue_last;
   logic                    start_accept;
   logic [2:0]              occupancy;
   logic                    unused_len;

   // Only the low ADDR_WIDTH bits of len address the RAM.
   assign unused_len = ^len[31:ADDR_WIDTH];

   assign pop          = tvalid & tready;
   assign push         = inflight;
   assign start_accept = (state == IDLE) && start;
   assign busy         = (state != IDLE);

   // Words already buffered plus the one coming back from the RAM, minus the
   // one leaving this cycle. Keeping this below two means the two-entry FIFO
   // always has room for every read that was issued.
   assign occupancy  = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
   assign ram_rd_en  = (state == RUN) && (occupancy < 3'd2);
   assign issue_last = ram_rd_en && (ram_addr == last_addr);

   // Next-state logic. RUN hands over to DRAIN once the final address has
   // been read. DRAIN then waits for the tlast beat to be accepted.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start) next_state = RUN;
         RUN:     if (issue_last) next_state = DRAIN;
         DRAIN:   if (pop && tlast) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // Read address counter. It holds at last_addr instead of wrapping, so the
   // RAM is never read past the end of the packet.
   always_ff @(posedge clk) begin
      if (rst) begin
         ram_addr  <= '0;
         last_addr <= '0;
      end else if (start_accept) begin
         ram_addr  <= '0;
         last_addr <= len[ADDR_WIDTH-1:0];
      end else if (ram_rd_en && !issue_last) begin
         ram_addr  <= ram_addr + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
      end
   end

   // Tracks the word the RAM is returning this cycle. The last-word tag
   // travels with it so tlast does not need a separate beat counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
      end else begin
         inflight      <= ram_rd_en;
         inflight_last <= issue_last;
      end
   end

   // Two-entry FIFO between the RAM read port and the stream output. A push
   // and a pop in the same cycle both happen and leave the count unchanged.
   always_ff @(posedge clk) begin
      if (rst) begin
         fifo_data[0] <= '0;
         fifo_data[1] <= '0;
         fifo_last[0] <= 1'b0;
         fifo_last[1] <= 1'b0;
         wr_ptr       <= 1'b0;
         rd_ptr       <= 1'b0;
         fifo_count   <= 2'd0;
      end else begin
         if (push) begin
            fifo_data[wr_ptr] <= ram_rd_data;
            fifo_last[wr_ptr] <= inflight_last;
            wr_ptr            <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};
      end
   end

   // The read throttle guarantees a word never arrives at a full FIFO.
   always_ff @(posedge clk) begin
      if (!rst) assert (!(push && (fifo_count == 2'd2)));
   end

   // Completion pulse, registered so it lands one cycle after the tlast
   // handshake, in the same cycle busy drops.
   always_ff @(posedge clk) begin
      if (rst) fwd_done <= 1'b0;
      else     fwd_done <= (state == DRAIN) && pop && tlast;
   end

   assign tvalid = (fifo_count != 2'd0);
   assign tdata  = fifo_data[rd_ptr];
   assign tlast  = tvalid && fifo_last[rd_ptr];

`ifdef PACKET_FORWARDER_TKEEP_EN
   logic [2:0] last_bytes_q;

   // Byte count of the final word, held for the whole packet.
   always_ff @(posedge clk) begin
      if (rst)               last_bytes_q <= 3'd0;
      else if (start_accept) last_bytes_q <= last_bytes;
   end

   // Byte enables in network order. An out-of-range count means a full word.
   always_comb begin
      tkeep = 4'b0000;
      if (tvalid) begin
         if (tlast) begin
            case (last_bytes_q)
               3'd1:    tkeep = 4'b1000;
               3'd2:    tkeep = 4'b1100;
               3'd3:    tkeep = 4'b1110;
               default: tkeep = 4'b1111;
            endcase
         end else begin
            tkeep = 4'b1111;
         end
      end
   end
`endif

endmodule

// File: tb/tb_packet_forwarder.sv
// ---------------------------------------------------------------------------
// tb_packet_forwarder
//
// Drives packet_forwarder from a behavioural packet_ram model that reads
// registered and holds its output between reads. Every accepted beat is
// compared against the list of words written for that packet. The bench
// also checks read addressing, latency, stall stability, the completion
// pulse and mid-packet reset.
// ---------------------------------------------------------------------------
module tb_packet_forwarder;

   localparam int AW = 10;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [31:0]   len;
   logic          busy;
   logic [AW-1:0] ram_addr;
   logic          ram_rd_en;
   logic [DW-1:0] ram_rd_data;
   logic [DW-1:0] tdata;
   logic          tvalid;
   logic          tready;
   logic          tlast;
   logic          fwd_done;
`ifdef PACKET_FORWARDER_TKEEP_EN
   logic [2:0]    last_bytes;
   logic [3:0]    tkeep;
`endif

   int totalChecks = 0;
   int badChecks   = 0;

   logic [DW-1:0] ramMem [0:(1<<AW)-1];

   packet_forwarder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .len         (len),
      .busy        (busy),
      .ram_addr    (ram_addr),
      .ram_rd_en   (ram_rd_en),
      .ram_rd_data (ram_rd_data),
      .tdata       (tdata),
      .tvalid      (tvalid),
      .tready      (tready),
      .tlast       (tlast),
`ifdef PACKET_FORWARDER_TKEEP_EN
      .last_bytes  (last_bytes),
      .tkeep       (tkeep),
`endif
      .fwd_done    (fwd_done)
   );

   // 10 ns clock.
   always #5 clk = ~clk;

   // packet_ram read port: registered read, output held when not enabled.
   always @(posedge clk) begin
      if (ram_rd_en) ram_rd_data <= ramMem[ram_addr];
   end

   // Single comparison point for the whole bench.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      totalChecks++;
      if (got !== exp) begin
         badChecks++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Expected byte enables, computed from the byte count directly.
   function automatic logic [3:0] expectedKeep(input int lb, input bit isLast);
      int n;
      logic [7:0] wide;
      if (!isLast) return 4'hF;
      n = (lb < 1 || lb > 4) ? 4 : lb;
      wide = 8'h0F << (4 - n);
      return wide[3:0];
   endfunction

   // tready pattern: 0 = always ready, 1 = 1,0,0,1,0,1 repeating, 2 = random.
   function automatic logic readyFor(input int mode, input int cycle);
      if (mode == 0) return 1'b1;
      if (mode == 1) begin
         case (cycle % 6)
            0, 3, 5: return 1'b1;
            default: return 1'b0;
         endcase
      end
      return 1'($urandom_range(0, 1));
   endfunction

   // Forwards one packet of pktLen+1 random words and checks it end to end.
   task automatic applyStimulus(input int pktLen, input int lastBytes, input int readyMode,
                                input bit restartMid);
      logic [31:0] expWords[$];
      logic [31:0] w;
      logic [31:0] prevData;
      logic        prevLast;
      bit          prevStall;
      int beat, rdCount, firstRd, firstValid, lastBeatCycle, doneCycle;
      beat = 0; rdCount = 0; firstRd = -1; firstValid = -1;
      lastBeatCycle = -1; doneCycle = -1; prevStall = 0;
      prevData = '0; prevLast = 1'b0;
      for (int i = 0; i <= pktLen; i++) begin
         w = $urandom;
         ramMem[i] = w;
         expWords.push_back(w);
      end
      @(negedge clk);
      len = {22'($urandom), 10'(pktLen)};
`ifdef PACKET_FORWARDER_TKEEP_EN
      last_bytes = 3'(lastBytes);
`endif
      start  = 1'b1;
      tready = readyFor(readyMode, 0);
      #1;
      checkOutput("busy_c0", {31'd0, busy}, 32'd0);
      for (int cycle = 1; cycle < 400 && doneCycle < 0; cycle++) begin
         @(negedge clk);
         start = (restartMid && cycle == 2);
         if (restartMid && cycle == 2) len = $urandom;
         tready = readyFor(readyMode, cycle);
         #1;
         if (ram_rd_en) begin
            checkOutput("rd_addr", 32'(ram_addr), 32'(rdCount));
            if (firstRd < 0) firstRd = cycle;
            rdCount++;
         end
         if (prevStall) begin
            checkOutput("stall_valid", {31'd0, tvalid}, 32'd1);
            checkOutput("stall_data", tdata, prevData);
            checkOutput("stall_last", {31'd0, tlast}, {31'd0, prevLast});
         end
         if (tvalid && firstValid < 0) firstValid = cycle;
         if (tvalid && tready) begin
            if (beat <= pktLen) begin
               checkOutput("beat_data", tdata, expWords[beat]);
               checkOutput("beat_last", {31'd0, tlast}, 32'(beat == pktLen));
`ifdef PACKET_FORWARDER_TKEEP_EN
               checkOutput("beat_keep", {28'd0, tkeep}, {28'd0, expectedKeep(lastBytes, beat == pktLen)});
`endif
            end else begin
               checkOutput("extra_beat", 32'(beat), 32'(pktLen));
            end
            if (tlast) lastBeatCycle = cycle;
            beat++;
         end
         prevStall = tvalid && !tready;
         prevData  = tdata;
         prevLast  = tlast;
         if (fwd_done) begin
            doneCycle = cycle;
            checkOutput("done_busy", {31'd0, busy}, 32'd0);
            checkOutput("done_after_last", 32'(cycle), 32'(lastBeatCycle + 1));
         end
      end
      checkOutput("done_seen", 32'(doneCycle >= 0), 32'd1);
      checkOutput("beat_count", 32'(beat), 32'(pktLen + 1));
      checkOutput("read_count", 32'(rdCount), 32'(pktLen + 1));
      checkOutput("first_rd_cycle", 32'(firstRd), 32'd1);
      checkOutput("first_valid_cycle", 32'(firstValid), 32'd3);
      if (readyMode == 0) checkOutput("done_cycle", 32'(doneCycle), 32'(pktLen + 4));
      start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         tready = 1'b1;
         #1;
         checkOutput("idle_no_done", {31'd0, fwd_done}, 32'd0);
         checkOutput("idle_no_valid", {31'd0, tvalid}, 32'd0);
         checkOutput("idle_no_rd", {31'd0, ram_rd_en}, 32'd0);
      end
   endtask

   // Starts a len=5 packet and resets it right after the second beat.
   task automatic resetMidPacket();
      int beats;
      beats = 0;
      for (int i = 0; i <= 5; i++) ramMem[i] = $urandom;
      @(negedge clk);
      len = 32'd5;
      start = 1'b1;
      tready = 1'b1;
      for (int cycle = 1; cycle < 50 && beats < 2; cycle++) begin
         @(negedge clk);
         start = 1'b0;
         #1;
         if (tvalid && tready) beats++;
      end
      checkOutput("rst_two_beats", 32'(beats), 32'd2);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      #1;
      rst = 1'b0;
      checkOutput("rst_mid_valid", {31'd0, tvalid}, 32'd0);
      checkOutput("rst_mid_busy", {31'd0, busy}, 32'd0);
      checkOutput("rst_mid_done", {31'd0, fwd_done}, 32'd0);
      checkOutput("rst_mid_rd", {31'd0, ram_rd_en}, 32'd0);
      @(negedge clk);
      #1;
      checkOutput("rst_after_done", {31'd0, fwd_done}, 32'd0);
   endtask

   initial begin
      rst    = 1'b1;
      start  = 1'b0;
      tready = 1'b0;
      len    = 32'd0;
`ifdef PACKET_FORWARDER_TKEEP_EN
      last_bytes = 3'd0;
`endif
      repeat (3) @(negedge clk);
      #1;
      checkOutput("rst_busy", {31'd0, busy}, 32'd0);
      checkOutput("rst_addr", 32'(ram_addr), 32'd0);
      checkOutput("rst_rd_en", {31'd0, ram_rd_en}, 32'd0);
      checkOutput("rst_tvalid", {31'd0, tvalid}, 32'd0);
      checkOutput("rst_tlast", {31'd0, tlast}, 32'd0);
      checkOutput("rst_done", {31'd0, fwd_done}, 32'd0);
      checkOutput("rst_tdata", tdata, 32'd0);
`ifdef PACKET_FORWARDER_TKEEP_EN
      checkOutput("rst_tkeep", {28'd0, tkeep}, 32'd0);
`endif
      rst = 1'b0;

      applyStimulus(3, 4, 0, 1'b0);
      applyStimulus(0, 1, 0, 1'b0);
      applyStimulus(7, 3, 1, 1'b0);
      applyStimulus(6, 4, 0, 1'b1);
      applyStimulus(2, 2, 0, 1'b0);
      resetMidPacket();
      applyStimulus(5, 4, 0, 1'b0);
      for (int n = 0; n < 10; n++) begin
         applyStimulus(int'($urandom_range(0, 20)), int'($urandom_range(0, 7)),
                       int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
      end

      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

endmodule
